put_get_responder: RTL

PUT_GET_RESPONDER -- requirements
Module: put_get_responder

---
 rtl/putget_pkg.sv | 13 +
 rtl/putget_ram.sv | 27 ++
 rtl/put_get_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/putget_pkg.sv
// Shared FSM state type and default geometry for the put/get responder.
package putget_pkg;

    localparam int PUTGET_WIDTH_DEFAULT = 32;
    localparam int PUTGET_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ACTIVE = 2'b01,
        FULL   = 2'b10
    } putget_state_e;

endpackage

// File: rtl/putget_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module putget_ram
    import putget_pkg::*;
#(
    parameter int WIDTH = PUTGET_WIDTH_DEFAULT,
    parameter int DEPTH = PUTGET_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/put_get_responder.sv
// Put/get FIFO responder with registered ready/occupancy/head outputs.
// Optional sticky protocol checker enabled by defining PUTGET_PROTO_CHECK_EN.
module put_get_responder
    import putget_pkg::*;
#(
    parameter int WIDTH = PUTGET_WIDTH_DEFAULT,
    parameter int DEPTH = PUTGET_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       put_datas,
    input  logic                   EN_put,
    output logic                   RDY_put,
    output logic [WIDTH-1:0]       get,
    input  logic                   EN_get,
    output logic                   RDY_get,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    putget_state_e    state_r;
    putget_state_e    state_next_s;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             rdy_put_r;
    logic             rdy_get_r;
    logic [WIDTH-1:0] get_r;
    logic [WIDTH-1:0] head_next_s;
    logic [WIDTH-1:0] ram_rdata_s;
    logic             do_put_s;
    logic             do_get_s;

    // Handshakes only fire against the registered ready flags.
    assign do_put_s = EN_put & rdy_put_r;
    assign do_get_s = EN_get & rdy_get_r;

    // The read port looks at the post-edge head so get can be registered.
    putget_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (do_put_s),
        .waddr (wr_ptr_r),
        .wdata (put_datas),
        .raddr (rd_ptr_next_s),
        .rdata (ram_rdata_s)
    );

    // FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY: begin
                if (do_put_s) begin
                    state_next_s = ACTIVE;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            ACTIVE: begin
                if (do_put_s && !do_get_s && (count_r == CNT_LAST)) begin
                    state_next_s = FULL;
                end else if (do_get_s && !do_put_s && (count_r == CNT_ONE)) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            FULL: begin
                if (do_get_s) begin
                    state_next_s = ACTIVE;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: begin
                state_next_s = EMPTY;
            end
        endcase
    end

    // Pointer, occupancy and next-head computation.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        head_next_s   = get_r;

        if (do_put_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (do_get_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        case ({do_put_s, do_get_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase

        // The RAM still holds the old word at a slot written this edge.
        if (count_next_s == CNT_ZERO) begin
            head_next_s = get_r;
        end else if (do_put_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = put_datas;
        end else begin
            head_next_s = ram_rdata_s;
        end
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= EMPTY;
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            count_r   <= CNT_ZERO;
            rdy_put_r <= 1'b0;
            rdy_get_r <= 1'b0;
            get_r     <= {WIDTH{1'b0}};
        end else begin
            state_r   <= state_next_s;
            wr_ptr_r  <= wr_ptr_next_s;
            rd_ptr_r  <= rd_ptr_next_s;
            count_r   <= count_next_s;
            rdy_put_r <= (state_next_s != FULL);
            rdy_get_r <= (state_next_s != EMPTY);
            get_r     <= head_next_s;
        end
    end

    assign RDY_put = rdy_put_r;
    assign RDY_get = rdy_get_r;
    assign count   = count_r;
    assign get     = get_r;

`ifdef PUTGET_PROTO_CHECK_EN
    logic err_r;

    // Sticky flag for any enable raised without its ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if ((EN_put && !rdy_put_r) || (EN_get && !rdy_get_r)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule
